// File: rtl/desc_in_sequencer.sv
// desc_in_sequencer: walks the descriptor ROM and packetises its bytes into EP0
// control-IN data packets, with retransmit on missing ACK and ZLP termination.
module desc_in_sequencer #(
    parameter int unsigned MAX_PKT = 8,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LEN_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  desc_len,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              abort,
    input  logic              in_token,
    input  logic              pkt_ack,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_last,
    output logic              tx_zlp,
    output logic              busy,
    output logic              done
);

    localparam logic [LEN_W-1:0] PKT_LEN  = LEN_W'(MAX_PKT);
    localparam logic [LEN_W-1:0] PKT_MASK = LEN_W'(MAX_PKT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TOKEN,
        S_ADDR,
        S_LATCH,
        S_SEND,
        S_SEND_ZLP,
        S_WAIT_ACK
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] base_addr, base_addr_nxt;
    logic [LEN_W-1:0]  total, total_nxt;
    logic [LEN_W-1:0]  offset, offset_nxt;
    logic [LEN_W-1:0]  pkt_off, pkt_off_nxt;
    logic              zlp_need, zlp_need_nxt;

    logic [ADDR_W-1:0] rom_addr_nxt;
    logic [7:0]        tx_data_nxt;
    logic              tx_valid_nxt, tx_last_nxt, tx_zlp_nxt;
    logic              busy_nxt, done_nxt;

    logic [LEN_W-1:0]  remaining, pkt_len, ack_offset, start_total;
    logic              is_zlp_pkt, ack_zlp_need, xfer_end, start_zlp, pkt_begin;

    // Packet sizing and end-of-transfer decisions from the committed offset
    assign remaining    = total - offset;
    assign pkt_len      = (remaining > PKT_LEN) ? PKT_LEN : remaining;
    assign is_zlp_pkt   = (pkt_len == '0);
    assign ack_offset   = offset + pkt_len;
    assign ack_zlp_need = zlp_need & ~is_zlp_pkt;
    assign xfer_end     = (ack_offset == total) && !ack_zlp_need;

    assign start_total  = (desc_len < req_len) ? desc_len : req_len;
    assign start_zlp    = (start_total == '0) ||
                          (((start_total & PKT_MASK) == '0) && (start_total < req_len));

    // A token starts a packet in WAIT_TOKEN, or retransmits in WAIT_ACK unless ACK wins
    assign pkt_begin = in_token &&
                       ((state == S_WAIT_TOKEN) || ((state == S_WAIT_ACK) && !pkt_ack));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:       if (start) state_nxt = S_WAIT_TOKEN;
                S_WAIT_TOKEN: if (in_token) state_nxt = is_zlp_pkt ? S_SEND_ZLP : S_ADDR;
                S_ADDR:       state_nxt = S_LATCH;
                S_LATCH:      state_nxt = S_SEND;
                S_SEND:       if (tx_ready) state_nxt = tx_last ? S_WAIT_ACK : S_ADDR;
                S_SEND_ZLP:   if (tx_ready) state_nxt = S_WAIT_ACK;
                S_WAIT_ACK: begin
                    if (pkt_ack) begin
                        state_nxt = xfer_end ? S_IDLE : S_WAIT_TOKEN;
                    end else if (in_token) begin
                        state_nxt = is_zlp_pkt ? S_SEND_ZLP : S_ADDR;
                    end
                end
                default:      state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        base_addr_nxt = base_addr;
        total_nxt     = total;
        offset_nxt    = offset;
        pkt_off_nxt   = pkt_off;
        zlp_need_nxt  = zlp_need;
        rom_addr_nxt  = rom_addr;
        tx_data_nxt   = tx_data;
        tx_valid_nxt  = tx_valid;
        tx_last_nxt   = tx_last;
        tx_zlp_nxt    = tx_zlp;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        if (abort) begin
            rom_addr_nxt = '0;
            tx_data_nxt  = '0;
            tx_valid_nxt = 1'b0;
            tx_last_nxt  = 1'b0;
            tx_zlp_nxt   = 1'b0;
            busy_nxt     = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_addr_nxt = start_addr;
                        total_nxt     = start_total;
                        offset_nxt    = '0;
                        pkt_off_nxt   = '0;
                        zlp_need_nxt  = start_zlp;
                        busy_nxt      = 1'b1;
                    end
                end
                S_LATCH: begin
                    tx_data_nxt  = rom_data;
                    tx_last_nxt  = (pkt_off == pkt_len - LEN_W'(1));
                    tx_zlp_nxt   = 1'b0;
                    tx_valid_nxt = 1'b1;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        tx_valid_nxt = 1'b0;
                        tx_last_nxt  = 1'b0;
                        if (!tx_last) begin
                            pkt_off_nxt  = pkt_off + LEN_W'(1);
                            rom_addr_nxt = base_addr + ADDR_W'(offset) + ADDR_W'(pkt_off + LEN_W'(1));
                        end
                    end
                end
                S_SEND_ZLP: begin
                    if (tx_ready) begin
                        tx_valid_nxt = 1'b0;
                        tx_last_nxt  = 1'b0;
                        tx_zlp_nxt   = 1'b0;
                    end
                end
                S_WAIT_ACK: begin
                    if (pkt_ack) begin
                        offset_nxt   = ack_offset;
                        zlp_need_nxt = ack_zlp_need;
                        if (xfer_end) begin
                            busy_nxt = 1'b0;
                            done_nxt = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (pkt_begin) begin
                pkt_off_nxt = '0;
                if (is_zlp_pkt) begin
                    tx_valid_nxt = 1'b1;
                    tx_last_nxt  = 1'b1;
                    tx_zlp_nxt   = 1'b1;
                    tx_data_nxt  = '0;
                end else begin
                    rom_addr_nxt = base_addr + ADDR_W'(offset);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_addr <= '0;
            total     <= '0;
            offset    <= '0;
            pkt_off   <= '0;
            zlp_need  <= 1'b0;
            rom_addr  <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
            tx_zlp    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            base_addr <= base_addr_nxt;
            total     <= total_nxt;
            offset    <= offset_nxt;
            pkt_off   <= pkt_off_nxt;
            zlp_need  <= zlp_need_nxt;
            rom_addr  <= rom_addr_nxt;
            tx_data   <= tx_data_nxt;
            tx_valid  <= tx_valid_nxt;
            tx_last   <= tx_last_nxt;
            tx_zlp    <= tx_zlp_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_desc_in_sequencer.sv
// tb_desc_in_sequencer: directed scenarios against a synchronous ROM model,
// each task checking packets, ZLPs, retransmits, wrap and abort behaviour.
module tb_desc_in_sequencer;

    localparam int unsigned MAX_PKT = 8;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned LEN_W   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  desc_len;
    logic [LEN_W-1:0]  req_len;
    logic              abort;
    logic              in_token;
    logic              pkt_ack;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic              tx_last;
    logic              tx_zlp;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    logic [7:0]        rom [0:1023];
    logic [7:0]        cap_data [0:63];
    logic              cap_last [0:63];
    logic              cap_zlp  [0:63];
    logic [ADDR_W-1:0] cap_addr [0:63];
    int                cap_n, cap_na, cap_lat;
    logic              cap_timeout;

    desc_in_sequencer #(
        .MAX_PKT (MAX_PKT),
        .ADDR_W  (ADDR_W),
        .LEN_W   (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .desc_len   (desc_len),
        .req_len    (req_len),
        .abort      (abort),
        .in_token   (in_token),
        .pkt_ack    (pkt_ack),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .tx_zlp     (tx_zlp),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [7:0] rom_val(input int a);
        return 8'((a * 7 + 3) ^ (a >> 4));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int a, input int dl, input int rl);
        start_addr = ADDR_W'(a);
        desc_len   = LEN_W'(dl);
        req_len    = LEN_W'(rl);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic pulse_ack();
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
    endtask

    // Pulse a token and capture one packet; tx_ready is assumed held high
    task automatic collect_packet();
        cap_n       = 0;
        cap_na      = 0;
        cap_lat     = -1;
        cap_timeout = 1'b1;
        in_token    = 1'b1;
        tick();
        in_token    = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if ((cap_na == 0 || rom_addr != cap_addr[cap_na-1]) && cap_na < 64) begin
                cap_addr[cap_na] = rom_addr;
                cap_na++;
            end
            if (tx_valid) begin
                if (cap_lat < 0) cap_lat = c;
                if (cap_n < 64) begin
                    cap_data[cap_n] = tx_data;
                    cap_last[cap_n] = tx_last;
                    cap_zlp[cap_n]  = tx_zlp;
                    cap_n++;
                end
                if (tx_last) begin
                    tick();
                    cap_timeout = 1'b0;
                    break;
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (rom_addr !== '0 || tx_data !== '0) begin
            failures++;
            $display("FAIL reset_data rom_addr=%0d tx_data=%0h exp=0/0", rom_addr, tx_data);
        end
        checks++;
        if ({tx_valid, tx_last, tx_zlp, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {tx_valid, tx_last, tx_zlp, busy, done});
        end
        rst = 1'b0;
        in_token = 1'b1;
        pkt_ack  = 1'b1;
        tick();
        in_token = 1'b0;
        pkt_ack  = 1'b0;
        tick();
        checks++;
        if ({tx_valid, busy, done} !== 3'b0) begin
            failures++;
            $display("FAIL idle_ignores_token got=%b exp=000", {tx_valid, busy, done});
        end
    endtask

    task automatic test_basic_18();
        do_start(0, 18, 64);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got=%b exp=1", busy);
        end
        for (int p = 0; p < 3; p++) begin
            int exp_len;
            exp_len = (p < 2) ? 8 : 2;
            collect_packet();
            checks++;
            if (cap_timeout !== 1'b0 || cap_n != exp_len) begin
                failures++;
                $display("FAIL basic_len pkt=%0d got=%0d exp=%0d timeout=%b", p, cap_n, exp_len, cap_timeout);
            end
            checks++;
            if (cap_lat != 3) begin
                failures++;
                $display("FAIL basic_latency pkt=%0d got=%0d exp=3", p, cap_lat);
            end
            for (int i = 0; i < cap_n && i < exp_len; i++) begin
                checks++;
                if (cap_data[i] !== rom_val(p*8 + i) || cap_last[i] !== (i == exp_len - 1) || cap_zlp[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_byte pkt=%0d i=%0d got=%0h/%b/%b exp=%0h/%b/0", p, i,
                             cap_data[i], cap_last[i], cap_zlp[i], rom_val(p*8 + i), (i == exp_len - 1));
                end
            end
            pulse_ack();
            checks++;
            if (done !== (p == 2) || busy !== (p != 2)) begin
                failures++;
                $display("FAIL basic_done pkt=%0d done=%b busy=%b exp=%b/%b", p, done, busy, (p == 2), (p != 2));
            end
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_zlp_16();
        do_start(100, 16, 64);
        for (int p = 0; p < 2; p++) begin
            collect_packet();
            checks++;
            if (cap_timeout !== 1'b0 || cap_n != 8) begin
                failures++;
                $display("FAIL zlp16_len pkt=%0d got=%0d exp=8", p, cap_n);
            end
            for (int i = 0; i < cap_n && i < 8; i++) begin
                checks++;
                if (cap_data[i] !== rom_val(100 + p*8 + i) || cap_last[i] !== (i == 7)) begin
                    failures++;
                    $display("FAIL zlp16_byte pkt=%0d i=%0d got=%0h/%b exp=%0h/%b", p, i,
                             cap_data[i], cap_last[i], rom_val(100 + p*8 + i), (i == 7));
                end
            end
            pulse_ack();
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL zlp16_early_done pkt=%0d done=%b busy=%b exp=0/1", p, done, busy);
            end
        end
        collect_packet();
        checks++;
        if (cap_timeout !== 1'b0 || cap_n != 1 || cap_zlp[0] !== 1'b1 || cap_last[0] !== 1'b1 || cap_data[0] !== 8'h00) begin
            failures++;
            $display("FAIL zlp16_zlp n=%0d zlp=%b last=%b data=%0h exp=1/1/1/0", cap_n, cap_zlp[0], cap_last[0], cap_data[0]);
        end
        checks++;
        if (cap_lat != 1) begin
            failures++;
            $display("FAIL zlp16_latency got=%0d exp=1", cap_lat);
        end
        pulse_ack();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zlp16_done done=%b busy=%b exp=1/0", done, busy);
        end
    endtask

    task automatic test_truncate();
        logic seen;
        do_start(0, 18, 8);
        collect_packet();
        checks++;
        if (cap_timeout !== 1'b0 || cap_n != 8 || cap_last[7] !== 1'b1 || cap_data[7] !== rom_val(7)) begin
            failures++;
            $display("FAIL trunc_pkt n=%0d last7=%b data7=%0h exp=8/1/%0h", cap_n, cap_last[7], cap_data[7], rom_val(7));
        end
        pulse_ack();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL trunc_done done=%b busy=%b exp=1/0", done, busy);
        end
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (tx_valid || busy) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL trunc_extra_token got=%b exp=0", seen);
        end
    endtask

    task automatic test_retransmit();
        logic seen;
        do_start(200, 20, 64);
        for (int r = 0; r < 2; r++) begin
            collect_packet();
            checks++;
            if (cap_timeout !== 1'b0 || cap_n != 8 || cap_lat != 3) begin
                failures++;
                $display("FAIL retx_len try=%0d got=%0d lat=%0d exp=8/3", r, cap_n, cap_lat);
            end
            for (int i = 0; i < cap_n && i < 8; i++) begin
                checks++;
                if (cap_data[i] !== rom_val(200 + i)) begin
                    failures++;
                    $display("FAIL retx_byte try=%0d i=%0d got=%0h exp=%0h", r, i, cap_data[i], rom_val(200 + i));
                end
            end
        end
        pkt_ack  = 1'b1;
        in_token = 1'b1;
        tick();
        pkt_ack  = 1'b0;
        in_token = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (tx_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL retx_ack_wins valid_seen=%b busy=%b done=%b exp=0/1/0", seen, busy, done);
        end
        for (int p = 1; p < 3; p++) begin
            int exp_len;
            exp_len = (p == 1) ? 8 : 4;
            collect_packet();
            checks++;
            if (cap_timeout !== 1'b0 || cap_n != exp_len) begin
                failures++;
                $display("FAIL retx_next_len pkt=%0d got=%0d exp=%0d", p, cap_n, exp_len);
            end
            for (int i = 0; i < cap_n && i < exp_len; i++) begin
                checks++;
                if (cap_data[i] !== rom_val(200 + p*8 + i) || cap_last[i] !== (i == exp_len - 1)) begin
                    failures++;
                    $display("FAIL retx_next_byte pkt=%0d i=%0d got=%0h/%b exp=%0h/%b", p, i,
                             cap_data[i], cap_last[i], rom_val(200 + p*8 + i), (i == exp_len - 1));
                end
            end
            pulse_ack();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL retx_done done=%b busy=%b exp=1/0", done, busy);
        end
    endtask

    task automatic test_zero_len();
        do_start(5, 0, 64);
        for (int r = 0; r < 2; r++) begin
            collect_packet();
            checks++;
            if (cap_timeout !== 1'b0 || cap_n != 1 || cap_zlp[0] !== 1'b1 || cap_lat != 1) begin
                failures++;
                $display("FAIL zero_zlp try=%0d n=%0d zlp=%b lat=%0d exp=1/1/1", r, cap_n, cap_zlp[0], cap_lat);
            end
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL zero_early_done try=%0d done=%b busy=%b exp=0/1", r, done, busy);
            end
        end
        pulse_ack();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done done=%b busy=%b exp=1/0", done, busy);
        end
    endtask

    task automatic test_wrap();
        do_start(1020, 8, 64);
        collect_packet();
        checks++;
        if (cap_timeout !== 1'b0 || cap_n != 8 || cap_na != 8) begin
            failures++;
            $display("FAIL wrap_len bytes=%0d addrs=%0d exp=8/8", cap_n, cap_na);
        end
        for (int i = 0; i < cap_na && i < 8; i++) begin
            checks++;
            if (cap_addr[i] !== ADDR_W'((1020 + i) % 1024) || cap_data[i] !== rom_val((1020 + i) % 1024)) begin
                failures++;
                $display("FAIL wrap_addr i=%0d addr=%0d data=%0h exp=%0d/%0h", i, cap_addr[i], cap_data[i],
                         (1020 + i) % 1024, rom_val((1020 + i) % 1024));
            end
        end
        pulse_ack();
        collect_packet();
        checks++;
        if (cap_timeout !== 1'b0 || cap_n != 1 || cap_zlp[0] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_zlp n=%0d zlp=%b exp=1/1", cap_n, cap_zlp[0]);
        end
        pulse_ack();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL wrap_done got=%b exp=1", done);
        end
    endtask

    task automatic test_abort();
        logic seen;
        do_start(0, 18, 64);
        tx_ready = 1'b0;
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (tx_valid) seen = 1'b1;
            else tick();
        end
        checks++;
        if (seen !== 1'b1 || tx_data !== rom_val(0) || tx_last !== 1'b0) begin
            failures++;
            $display("FAIL abort_first_byte valid=%b data=%0h last=%b exp=1/%0h/0", seen, tx_data, tx_last, rom_val(0));
        end
        tick();
        tick();
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== rom_val(0) || tx_last !== 1'b0 || tx_zlp !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold valid=%b data=%0h last=%b zlp=%b exp=1/%0h/0/0", tx_valid, tx_data, tx_last, tx_zlp, rom_val(0));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({tx_valid, tx_last, tx_zlp, busy, done} !== 5'b0 || tx_data !== 8'h00 || rom_addr !== '0) begin
            failures++;
            $display("FAIL abort_outputs flags=%b data=%0h addr=%0d exp=00000/0/0",
                     {tx_valid, tx_last, tx_zlp, busy, done}, tx_data, rom_addr);
        end
        tx_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (done || tx_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got=%b exp=0", seen);
        end
        do_start(300, 10, 64);
        for (int p = 0; p < 2; p++) begin
            int exp_len;
            exp_len = (p == 0) ? 8 : 2;
            collect_packet();
            checks++;
            if (cap_timeout !== 1'b0 || cap_n != exp_len) begin
                failures++;
                $display("FAIL abort_rerun_len pkt=%0d got=%0d exp=%0d", p, cap_n, exp_len);
            end
            for (int i = 0; i < cap_n && i < exp_len; i++) begin
                checks++;
                if (cap_data[i] !== rom_val(300 + p*8 + i) || cap_last[i] !== (i == exp_len - 1)) begin
                    failures++;
                    $display("FAIL abort_rerun_byte pkt=%0d i=%0d got=%0h/%b exp=%0h/%b", p, i,
                             cap_data[i], cap_last[i], rom_val(300 + p*8 + i), (i == exp_len - 1));
                end
            end
            pulse_ack();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_rerun_done done=%b busy=%b exp=1/0", done, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = rom_val(i);
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        desc_len   = '0;
        req_len    = '0;
        abort      = 1'b0;
        in_token   = 1'b0;
        pkt_ack    = 1'b0;
        tx_ready   = 1'b1;
        test_reset();
        test_basic_18();
        test_zlp_16();
        test_truncate();
        test_retransmit();
        test_zero_len();
        test_wrap();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
